// File: rtl/jk_excitation_driver_if.sv
// Word handshake between the control sequencer and the JK excitation driver.
// The sequencer is the master; the driver is the slave.
interface jk_excitation_driver_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/jk_excitation_driver.sv
// Serialises a word LSB first into a master-slave JK flop. Each bit gets J/K excitation
// from the fed-back Qs, followed by a read-back check that counts mismatches.
module jk_excitation_driver #(
    parameter int WIDTH      = 4,
    parameter int FB_LAT     = 1,
    parameter int USE_TOGGLE = 0,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 clear,
    jk_excitation_driver_if.slave in_if,
    output logic                 Set,
    output logic                 Reset,
    input  logic                 Qs,
    input  logic                 stat_clr,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     mism_cnt
);
    localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int WAIT_W = (FB_LAT > 1) ? $clog2(FB_LAT) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WIDTH - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(FB_LAT - 1);

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] sh_reg;
    logic [WIDTH-1:0] sh_next;
    logic [IDX_W-1:0] bit_idx_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;

    assign sh_next = sh_reg >> 1;

    // J/K pair ({Set, Reset}) that moves the flop from q to target t.
    function automatic logic [1:0] excite(input logic t, input logic q);
        if (t == q)
            return 2'b00;
        else if (USE_TOGGLE != 0)
            return 2'b11;
        else
            return t ? 2'b10 : 2'b01;
    endfunction

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_reg      <= IDLE;
            in_if.in_ready <= 1'b0;
            Set            <= 1'b0;
            Reset          <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            mism_cnt       <= '0;
            sh_reg         <= '0;
            bit_idx_reg    <= '0;
            wait_cnt_reg   <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_if.in_valid && in_if.in_ready) begin
                        sh_reg         <= in_if.in_data;
                        bit_idx_reg    <= '0;
                        {Set, Reset}   <= excite(in_if.in_data[0], Qs);
                        in_if.in_ready <= 1'b0;
                        state_reg      <= DRIVE;
                    end else begin
                        in_if.in_ready <= 1'b1;
                    end
                end
                DRIVE: begin
                    Set          <= 1'b0;
                    Reset        <= 1'b0;
                    wait_cnt_reg <= '0;
                    state_reg    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt_reg == LAST_WAIT)
                        state_reg <= CHECK;
                    else
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                end
                CHECK: begin
                    if (Qs != sh_reg[0]) begin
                        err <= 1'b1;
                        if (mism_cnt != {CNT_W{1'b1}})
                            mism_cnt <= mism_cnt + 1'b1;
                    end
                    if (bit_idx_reg == LAST_IDX) begin
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        // Qs sampled here is the flop state the next bit starts from.
                        sh_reg       <= sh_next;
                        bit_idx_reg  <= bit_idx_reg + 1'b1;
                        {Set, Reset} <= excite(sh_next[0], Qs);
                        state_reg    <= DRIVE;
                    end
                end
                DONE: begin
                    in_if.in_ready <= 1'b1;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
            // Placed last so a clear overrides a same-edge mismatch update.
            if (stat_clr) begin
                err      <= 1'b0;
                mism_cnt <= '0;
            end
        end
    end
endmodule
